// File: rtl/inst_fetch.sv
// Serial instruction fetch: requests 16-bit words, assembles NSHIFT-bit chunks, queues {word, pc}.
// Define INST_FETCH_PREFETCH_EN for a 2-deep queue that prefetches while the decoder holds the head.
module inst_fetch #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 16 / NSHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              req_valid,
  output logic [15:0]       req_addr,
  input  logic              req_started,
  input  logic              rx_data_valid,
  input  logic [NSHIFT-1:0] rx_data,
  input  logic              rx_done,
  output logic              inst_valid,
  output logic [15:0]       inst,
  output logic [15:0]       inst_pc,
  input  logic              inst_done,
  input  logic              jump_valid,
  input  logic [15:0]       jump_addr
);

`ifdef INST_FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam logic [1:0] DEPTH = 2'(D);
  localparam int ASM_W = NSHIFT * PAYLOAD_CYCLES;

  typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

  state_t             state_reg;
  logic               req_valid_reg;
  logic               discard_reg;
  logic [15:0]        fetch_addr_reg;
  logic [15:0]        rx_pc_reg;
  logic [ASM_W-1:0]   asm_reg;
  logic [1:0]         count_reg;
  logic [15:0]        q_word_reg [D];
  logic [15:0]        q_pc_reg   [D];

  logic               pop;
  logic               push;
  logic [1:0]         count_next;
  logic [1:0]         wr_idx;
  logic [ASM_W-1:0]   asm_next;
  logic [15:0]        jump_target;

  always_comb begin
    pop         = inst_done && (count_reg != 2'd0);
    // A jump flushes the queue, so it also cancels any push landing in the same cycle.
    push        = (state_reg == RECV) && rx_done && !discard_reg && !jump_valid;
    wr_idx      = count_reg - {1'b0, pop};
    count_next  = count_reg + {1'b0, push} - {1'b0, pop};
    if (jump_valid) begin
      count_next = 2'd0;
    end
    asm_next    = {rx_data, asm_reg[ASM_W-1:NSHIFT]};
    jump_target = jump_addr & 16'hFFFE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_valid_reg  <= 1'b0;
      discard_reg    <= 1'b0;
      fetch_addr_reg <= 16'h0000;
      rx_pc_reg      <= 16'h0000;
      asm_reg        <= '0;
      count_reg      <= 2'd0;
      for (int i = 0; i < D; i++) begin
        q_word_reg[i] <= 16'h0000;
        q_pc_reg[i]   <= 16'h0000;
      end
    end else begin
      count_reg <= count_next;
      if (pop) begin
        for (int i = 0; i < D - 1; i++) begin
          q_word_reg[i] <= q_word_reg[i+1];
          q_pc_reg[i]   <= q_pc_reg[i+1];
        end
      end
      // Written after the shift so a simultaneous pop+push lands in the freed slot.
      for (int i = 0; i < D; i++) begin
        if (push && (wr_idx == 2'(i))) begin
          q_word_reg[i] <= asm_next[ASM_W-1 -: 16];
          q_pc_reg[i]   <= rx_pc_reg;
        end
      end

      if (jump_valid) begin
        fetch_addr_reg <= jump_target;
      end else if (state_reg == REQ && req_started) begin
        fetch_addr_reg <= fetch_addr_reg + 16'd2;
      end

      case (state_reg)
        IDLE: begin
          // Nothing is in flight here, so a free slot after this cycle's pop/flush is enough.
          if (count_next < DEPTH) begin
            state_reg     <= REQ;
            req_valid_reg <= 1'b1;
          end
        end
        REQ: begin
          if (req_started) begin
            state_reg     <= RECV;
            req_valid_reg <= 1'b0;
            rx_pc_reg     <= fetch_addr_reg;
            discard_reg   <= jump_valid;
          end
        end
        RECV: begin
          if (rx_data_valid) begin
            asm_reg <= asm_next;
          end
          if (rx_done) begin
            state_reg   <= IDLE;
            discard_reg <= 1'b0;
          end else if (jump_valid) begin
            discard_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = req_valid_reg;
  assign req_addr   = fetch_addr_reg;
  assign inst_valid = (count_reg != 2'd0);
  assign inst       = q_word_reg[0];
  assign inst_pc    = q_pc_reg[0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: random memory latency, decoder stalls and jumps checked against a program-order stream model.
`timescale 1ns/1ps
module tb_inst_fetch;
  localparam int NSHIFT  = 2;
  localparam int PAYLOAD = 8;
`ifdef INST_FETCH_PREFETCH_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_started = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [1:0]  rx_data = 2'd0;
  logic        rx_done = 1'b0;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_done = 1'b0;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_addr = 16'h0000;

  always #5 clk = ~clk;

  inst_fetch #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PAYLOAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_started(req_started),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_done(rx_done),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_done(inst_done),
    .jump_valid(jump_valid), .jump_addr(jump_addr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: fixed word at 0, a scrambled function of the address elsewhere.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] t;
    if (a == 16'h0000) return 16'h1234;
    t = {16'h0000, a} * 32'h0000_9E37;
    return t[23:8] ^ 16'h5A3C;
  endfunction

  // ---------------- memory responder ----------------
  bit          mem_busy = 1'b0;
  bit          mem_hold = 1'b0;
  bit          stray_pending = 1'b0;
  int          stray_cnt = 0;
  int          chunk_idx = 0;
  logic [15:0] cur_word = 16'h0000;
  logic [15:0] req_log [$];

  initial begin
    forever begin
      @(posedge clk); #1;
      req_started = 1'b0; rx_data_valid = 1'b0; rx_done = 1'b0; rx_data = 2'd0;
      if (!rst_n) begin
        mem_busy = 1'b0; chunk_idx = 0;
      end else if (stray_pending) begin
        rx_data_valid = 1'b1; rx_data = 2'($urandom); rx_done = (stray_cnt == 2);
        stray_cnt++;
        if (stray_cnt == 3) begin stray_pending = 1'b0; stray_cnt = 0; end
      end else if (mem_busy) begin
        if ($urandom_range(0, 3) != 0) begin
          rx_data_valid = 1'b1;
          rx_data = cur_word[NSHIFT*chunk_idx +: NSHIFT];
          rx_done = (chunk_idx == PAYLOAD - 1);
          chunk_idx++;
          if (chunk_idx == PAYLOAD) mem_busy = 1'b0;
        end
      end else if (req_valid && !mem_hold && $urandom_range(0, 2) != 0) begin
        req_started = 1'b1;
        req_log.push_back(req_addr);
        cur_word = mem_word(req_addr);
        mem_busy = 1'b1; chunk_idx = 0;
        $display("[TB] request accepted addr=0x%04h", req_addr);
      end
    end
  end

  // ---------------- decoder ----------------
  int dec_mode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      inst_done = (dec_mode != 0) && ($urandom_range(0, 1) == 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed { logic [15:0] word; logic [15:0] pc; } entry_t;
  entry_t      exp_q [$];
  logic [15:0] stream_pc = 16'h0000;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_inst = 16'h0000;
  logic [15:0] prev_pc = 16'h0000;

  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); stream_pc = 16'h0000; prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", inst_valid, 1);
          check("hold_inst", inst, prev_inst);
          check("hold_pc", inst_pc, prev_pc);
        end
        prev_hold = inst_valid && !inst_done && !jump_valid;
        prev_inst = inst; prev_pc = inst_pc;
        if (jump_valid) begin
          exp_q.delete();
          stream_pc = jump_addr & 16'hFFFE;
        end else if (inst_valid && inst_done) begin
          while (exp_q.size() < 4) begin
            exp_q.push_back({mem_word(stream_pc), stream_pc});
            stream_pc = stream_pc + 16'd2;
          end
          e = exp_q.pop_front();
          check("pop_inst", inst, e.word);
          check("pop_pc", inst_pc, e.pc);
          $display("[TB] consumed pc=0x%04h inst=0x%04h (expected pc=0x%04h inst=0x%04h)", inst_pc, inst, e.pc, e.word);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 16'h0000);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);

    // First fetch after reset release, decoder stalled.
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_req_valid", req_valid, 1);
    check("first_req_addr", req_addr, 16'h0000);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rx_done && rx_data_valid) got = 1'b1;
    end
    check("first_rx_done_seen", got, 1);
    check("valid_before_push", inst_valid, 0);
    @(negedge clk);
    check("first_inst_valid", inst_valid, 1);
    check("first_inst", inst, 16'h1234);
    check("first_inst_pc", inst_pc, 16'h0000);

    // Prolonged stall: D words requested in total, no more.
    repeat (40) @(negedge clk);
    check("stall_req_count", req_log.size(), D);
    check("stall_last_addr", (req_log.size() > 0) ? req_log[$] : 16'hDEAD, 16'(2 * (D - 1)));
    check("stall_head_inst", inst, 16'h1234);
    dec_mode = 1;

    // Random run with jumps.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      jump_valid = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       jump_addr = 16'hFFFE;
        1:       jump_addr = 16'h4001;
        default: jump_addr = 16'($urandom);
      endcase
    end
    @(posedge clk); #1;
    jump_valid = 1'b0;

    // Jump to 0x4001 in the middle of a word.
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_busy && chunk_idx >= 2 && chunk_idx <= 5) got = 1'b1;
    end
    check("midrecv_found", got, 1);
    @(posedge clk); #1;
    req_log.delete();
    jump_valid = 1'b1; jump_addr = 16'h4001;
    @(posedge clk); #1;
    jump_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (inst_valid) got = 1'b1;
    end
    check("jump_inst_seen", got, 1);
    check("jump_head_pc", inst_pc, 16'h4000);
    check("jump_req_addr", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h4000);

    // Jump to 0xFFFE with memory idle: address must wrap to 0x0000.
    @(negedge clk);
    mem_hold = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (!mem_busy) got = 1'b1;
    end
    check("mem_idle_found", got, 1);
    @(posedge clk); #1;
    req_log.delete();
    jump_valid = 1'b1; jump_addr = 16'hFFFE;
    @(posedge clk); #1;
    jump_valid = 1'b0; mem_hold = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (req_log.size() >= 2) got = 1'b1;
    end
    check("wrap_two_reqs", got, 1);
    check("wrap_req0", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'hFFFE);
    check("wrap_req1", (req_log.size() > 1) ? req_log[1] : 16'hDEAD, 16'h0000);

    // Reset asserted during chunk 4 of a word.
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_busy && chunk_idx == 4) got = 1'b1;
    end
    check("chunk4_found", got, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_req_valid", req_valid, 0);
    check("async_req_addr", req_addr, 16'h0000);
    check("async_inst_valid", inst_valid, 0);
    check("async_inst", inst, 16'h0000);
    check("async_inst_pc", inst_pc, 16'h0000);
    stray_pending = 1'b1;
    req_log.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (req_log.size() >= 1) got = 1'b1;
    end
    check("restart_req_seen", got, 1);
    check("restart_req_addr", (req_log.size() > 0) ? req_log[0] : 16'hDEAD, 16'h0000);

    repeat (200) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
